branch_pc_ctrl: RTL and testbench

Fetch-side PC and IF/ID control that consumes brCond from the branch condition checker in ID.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched instruction into the IF/ID latch.
- On a taken branch, redirects the PC and flushes the wrong-path instruction (one-bubble penalty).
- Honours hazard-unit freeze and keeps saturating taken-branch/stall counters for performance debug.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 74 +++++++
 rtl/branch_pc_ctrl.sv | 118 +++++++++++
 tb/tb_branch_pc_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch/decode slice.
// Provides default address width, reset PC, instruction width, the NOP
// encoding and the branch-communication encoding used between the control
// unit, the branch condition checker and the fetch-side PC controller.
package pipeline_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Branch kind requested by the control unit for the instruction in ID.
    typedef enum logic [1:0] {
        CU_BR_NONE = 2'd0,
        CU_BR_BEQ  = 2'd1,
        CU_BR_BNE  = 2'd2,
        CU_BR_JMP  = 2'd3
    } cu_branch_comm_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline latch holding a PC / instruction / valid triple.
// Priority per edge: hold > clear > load; with none asserted it holds.
// A cleared latch carries PC 0, the NOP encoding and valid=0.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   hold              keep current contents (stall)
//   clear             replace contents with a bubble (flush)
//   load              capture pc_in / instr_in as a valid instruction
//   pc_in, instr_in   incoming PC and instruction
//   pc_o, instr_o     latched PC and instruction
//   valid_o           latch holds a real instruction
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               clear,
    input  logic               load,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_d,    pc_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               valid_d, valid_q;

    // Next-state selection for the latch contents.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (hold) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (clear) begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end else begin
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end
    end

    // Latch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch-side PC and IF/ID control.
// Holds the PC (driving the instruction-memory address), registers fetched
// instructions into IF/ID, redirects on a taken branch with a one-bubble
// penalty, honours the hazard freeze and keeps saturating debug counters.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   freeze       hazard stall: hold PC and IF/ID, brCond ignored
//   brCond       branch taken for the instruction currently in IF/ID
//   brOffset     signed word offset of the ID instruction
//   instrIn      instruction-memory read data for imemAddr
//   imemAddr     current PC
//   idPc         PC of the IF/ID instruction
//   idInstr      IF/ID instruction (NOP when invalid)
//   idValid      IF/ID holds a real instruction
//   flush        high for the cycle after a redirect
//   brTakenCnt   saturating taken-branch count
//   stallCnt     saturating freeze-cycle count
module branch_pc_ctrl
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               brCond,
    input  logic [15:0]        brOffset,
    input  logic [INSTR_W-1:0] instrIn,
    output logic [ADDR_W-1:0]  imemAddr,
    output logic [ADDR_W-1:0]  idPc,
    output logic [INSTR_W-1:0] idInstr,
    output logic               idValid,
    output logic               flush,
    output logic [CNT_W-1:0]   brTakenCnt,
    output logic [CNT_W-1:0]   stallCnt
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              flush_d, flush_q;
    logic [CNT_W-1:0]  br_cnt_d, br_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

    logic [ADDR_W-1:0] id_pc_s;
    logic              id_valid_s;
    logic [ADDR_W-1:0] off_ext_s;
    logic [ADDR_W-1:0] target_s;
    logic              br_taken_s;

    // Word offset sign-extended to address width, then scaled to bytes;
    // the sum wraps naturally modulo 2^ADDR_W.
    assign off_ext_s  = {{(ADDR_W-16){brOffset[15]}}, brOffset};
    assign target_s   = id_pc_s + PC_STEP + (off_ext_s << 2);

    // A branch only counts when the ID instruction is real and not stalled.
    assign br_taken_s = brCond & id_valid_s & ~freeze;

    // PC, flush marker and statistics next-state.
    always_comb begin
        pc_d        = pc_q;
        flush_d     = 1'b0;
        br_cnt_d    = br_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (freeze) begin
            pc_d        = pc_q;
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end else if (br_taken_s) begin
            pc_d     = target_s;
            flush_d  = 1'b1;
            br_cnt_d = (&br_cnt_q) ? br_cnt_q : br_cnt_q + CNT_W'(1);
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC, flush and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            br_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            br_cnt_q    <= br_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The instruction fetched in the branch cycle is the wrong path, so the
    // latch is cleared instead of loaded.
    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold     (freeze),
        .clear    (br_taken_s),
        .load     (1'b1),
        .pc_in    (pc_q),
        .instr_in (instrIn),
        .pc_o     (id_pc_s),
        .instr_o  (idInstr),
        .valid_o  (id_valid_s)
    );

    assign imemAddr   = pc_q;
    assign idPc       = id_pc_s;
    assign idValid    = id_valid_s;
    assign flush      = flush_q;
    assign brTakenCnt = br_cnt_q;
    assign stallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl (CNT_W=4 so saturation is reachable).
module tb_branch_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        brCond;
    logic [15:0] brOffset;
    logic [31:0] instrIn;
    logic [31:0] imemAddr;
    logic [31:0] idPc;
    logic [31:0] idInstr;
    logic        idValid;
    logic        flush;
    logic [3:0]  brTakenCnt;
    logic [3:0]  stallCnt;

    int checks;
    int failures;

    branch_pc_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .brCond     (brCond),
        .brOffset   (brOffset),
        .instrIn    (instrIn),
        .imemAddr   (imemAddr),
        .idPc       (idPc),
        .idInstr    (idInstr),
        .idValid    (idValid),
        .flush      (flush),
        .brTakenCnt (brTakenCnt),
        .stallCnt   (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        freeze   = 1'b0;
        brCond   = 1'b0;
        brOffset = 16'h0000;
        instrIn  = 32'h1111_1111;

        // 1. reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pc", imemAddr, 32'h0);
            check("rst_valid", {31'd0, idValid}, 32'd0);
        end
        check("rst_instr", idInstr, 32'h0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_brcnt", {28'd0, brTakenCnt}, 32'd0);
        check("rst_stcnt", {28'd0, stallCnt}, 32'd0);
        rst = 1'b0;
        step();
        check("seq_pc4", imemAddr, 32'h4);
        check("seq_valid1", {31'd0, idValid}, 32'd1);
        check("seq_idpc0", idPc, 32'h0);
        check("seq_instr", idInstr, 32'h1111_1111);
        step();
        check("seq_pc8", imemAddr, 32'h8);
        check("seq_idpc4", idPc, 32'h4);
        step();
        check("seq_idpc8", idPc, 32'h8);

        // 2. taken branch from idPc=8, offset 3 -> 0x18
        brOffset = 16'h0003;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("br_pc", imemAddr, 32'h18);
        check("br_valid", {31'd0, idValid}, 32'd0);
        check("br_instr", idInstr, 32'h0);
        check("br_idpc", idPc, 32'h0);
        check("br_flush", {31'd0, flush}, 32'd1);
        check("br_cnt1", {28'd0, brTakenCnt}, 32'd1);
        step();
        check("br_idpc18", idPc, 32'h18);
        check("br_flush0", {31'd0, flush}, 32'd0);
        check("br_pc1c", imemAddr, 32'h1C);

        // 3. negative offsets and wrap: 0x18 -> 0x10
        brOffset = 16'hFFFD;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("neg_pc10", imemAddr, 32'h10);
        step();
        check("neg_idpc10", idPc, 32'h10);
        brOffset = 16'hFFFC;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("neg_pc04", imemAddr, 32'h4);
        step();
        brOffset = 16'hFFFE;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("neg_pc00", imemAddr, 32'h0);
        step();
        check("neg_idpc0", idPc, 32'h0);
        brOffset = 16'hFFFE;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("wrap_pc", imemAddr, 32'hFFFF_FFFC);
        check("wrap_cnt", {28'd0, brTakenCnt}, 32'd5);
        step();
        check("wrap_idpc", idPc, 32'hFFFF_FFFC);
        check("wrap_pcinc", imemAddr, 32'h0);
        // first instruction at the target branches again straight away
        brOffset = 16'h0002;
        brCond   = 1'b1;
        step();
        brCond = 1'b0;
        check("b2b_pc", imemAddr, 32'h8);
        check("b2b_cnt", {28'd0, brTakenCnt}, 32'd6);
        step();
        check("b2b_idpc", idPc, 32'h8);

        // 4. freeze overrides brCond, release takes the branch
        freeze   = 1'b1;
        brCond   = 1'b1;
        brOffset = 16'h0010;
        step();
        step();
        check("frz_pc", imemAddr, 32'hC);
        check("frz_idpc", idPc, 32'h8);
        check("frz_valid", {31'd0, idValid}, 32'd1);
        check("frz_flush", {31'd0, flush}, 32'd0);
        check("frz_stcnt", {28'd0, stallCnt}, 32'd2);
        check("frz_brcnt", {28'd0, brTakenCnt}, 32'd6);
        freeze = 1'b0;
        step();
        brCond = 1'b0;
        check("rel_pc", imemAddr, 32'h4C);
        check("rel_flush", {31'd0, flush}, 32'd1);
        check("rel_brcnt", {28'd0, brTakenCnt}, 32'd7);

        // 5. asynchronous reset while flush is high
        rst = 1'b1;
        #1;
        check("arst_pc", imemAddr, 32'h0);
        check("arst_flush", {31'd0, flush}, 32'd0);
        check("arst_idpc", idPc, 32'h0);
        check("arst_brcnt", {28'd0, brTakenCnt}, 32'd0);
        check("arst_stcnt", {28'd0, stallCnt}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_rel_pc", imemAddr, 32'h4);
        check("arst_rel_valid", {31'd0, idValid}, 32'd1);

        // 6. stall counter saturation, brCond during a bubble
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check("sat_15", {28'd0, stallCnt}, 32'd15);
        end
        check("sat_hold", {28'd0, stallCnt}, 32'd15);
        check("sat_pc", imemAddr, 32'h4);
        freeze   = 1'b0;
        brOffset = 16'h0005;
        brCond   = 1'b1;
        step();
        check("bub_pc18", imemAddr, 32'h18);
        check("bub_valid0", {31'd0, idValid}, 32'd0);
        brOffset = 16'h0100;
        step();
        brCond = 1'b0;
        check("bub_noredir", imemAddr, 32'h1C);
        check("bub_idpc", idPc, 32'h18);
        check("bub_cnt", {28'd0, brTakenCnt}, 32'd1);
        check("bub_flush", {31'd0, flush}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
